// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl
// Brief    : Real-time hour/minute/second keeper with a debounced two-button
//            run/set state machine and set-field blink control.
// Revision : 1.0
// ============================================================================
module clock_mode_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int DB_CYCLES = 2_000_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    output logic [5:0] hour_o,
    output logic [5:0] minute_o,
    output logic [5:0] second_o,
    output logic [1:0] mode_o,
    output logic [2:0] field_sel_o,
    output logic       blank_o,
    output logic       tick_1hz_o
);

    localparam int PW  = $clog2(TICK_DIV + 1);
    localparam int BW  = $clog2(BLINK_DIV + 1);
    localparam int DBW = $clog2(DB_CYCLES + 1);

    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10,
        ST_SET_S = 2'b11
    } state_t;

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_inc_i, btn_mode_i};

    // Per button: synchronizer, debounce on a stable sample, rising-edge press.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic           sync1_q;
        logic           sync2_q;
        logic           samp_q;
        logic           db_q;
        logic           db_prev_q;
        logic [DBW-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                samp_q    <= 1'b0;
                db_q      <= 1'b0;
                db_prev_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= w_btn_raw[b];
                sync2_q   <= sync1_q;
                db_prev_q <= db_q;
                if (sync2_q != samp_q) begin
                    samp_q <= sync2_q;
                    cnt_q  <= '0;
                end else if (samp_q != db_q) begin
                    if (cnt_q == DB_LAST) begin
                        db_q  <= samp_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + DBW'(1);
                    end
                end
            end
        end

        assign w_press[b] = db_q & ~db_prev_q;
    end

    logic w_mode_press;
    logic w_inc_press;

    assign w_mode_press = w_press[0];
    assign w_inc_press  = w_press[1];

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
        return (v == last) ? 6'd0 : v + 6'd1;
    endfunction

    state_t          state_q;
    logic [PW-1:0]   presc_q;
    logic [BW-1:0]   blink_cnt_q;
    logic [5:0]      hour_q;
    logic [5:0]      minute_q;
    logic [5:0]      second_q;
    logic [2:0]      field_sel_q;
    logic            blank_q;
    logic            tick_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            hour_q      <= 6'd0;
            minute_q    <= 6'd0;
            second_q    <= 6'd0;
            field_sel_q <= 3'b000;
            blank_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (presc_q == PRESC_LAST) begin
                        presc_q  <= '0;
                        tick_q   <= 1'b1;
                        second_q <= wrap_inc(second_q, 6'd59);
                        if (second_q == 6'd59) begin
                            minute_q <= wrap_inc(minute_q, 6'd59);
                            if (minute_q == 6'd59) begin
                                hour_q <= wrap_inc(hour_q, 6'd23);
                            end
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                    // A tick on the same edge is still applied above.
                    if (w_mode_press) begin
                        state_q     <= ST_SET_H;
                        presc_q     <= '0;
                        field_sel_q <= 3'b100;
                    end
                end
                default: begin
                    presc_q <= '0;
                    if (w_inc_press) begin
                        case (state_q)
                            ST_SET_H: hour_q   <= wrap_inc(hour_q, 6'd23);
                            ST_SET_M: minute_q <= wrap_inc(minute_q, 6'd59);
                            default:  second_q <= wrap_inc(second_q, 6'd59);
                        endcase
                    end
                    if (w_mode_press) begin
                        case (state_q)
                            ST_SET_H: begin
                                state_q     <= ST_SET_M;
                                field_sel_q <= 3'b010;
                            end
                            ST_SET_M: begin
                                state_q     <= ST_SET_S;
                                field_sel_q <= 3'b001;
                            end
                            default: begin
                                state_q     <= ST_RUN;
                                field_sel_q <= 3'b000;
                            end
                        endcase
                    end
                end
            endcase

            // Phase restarts on every state change so the new field shows first.
            if (w_mode_press || state_q == ST_RUN) begin
                blink_cnt_q <= '0;
                blank_q     <= 1'b0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blank_q     <= ~blank_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    assign hour_o      = hour_q;
    assign minute_o    = minute_q;
    assign second_o    = second_q;
    assign mode_o      = state_q;
    assign field_sel_o = field_sel_q;
    assign blank_o     = blank_q;
    assign tick_1hz_o  = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_mode_ctrl
// Brief    : Directed self-checking bench for clock_mode_ctrl (small dividers).
// Revision : 1.0
// ============================================================================
module tb_clock_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] hour_o, minute_o, second_o;
    logic [1:0] mode_o;
    logic [2:0] field_sel_o;
    logic       blank_o, tick_1hz_o;

    int tests_run = 0;
    int tests_failed = 0;

    clock_mode_ctrl #(.TICK_DIV(10), .DB_CYCLES(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst(rst), .btn_mode_i(btn_mode), .btn_inc_i(btn_inc),
        .hour_o(hour_o), .minute_o(minute_o), .second_o(second_o),
        .mode_o(mode_o), .field_sel_o(field_sel_o), .blank_o(blank_o),
        .tick_1hz_o(tick_1hz_o)
    );

    always #5 clk = ~clk;

    task automatic press_btn(input bit sel_mode, input int hold);
        if (sel_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        tests_run++; if (hour_o !== 6'd0) begin tests_failed++; $display("FAIL %s_hour: got %0d expected 0", tag, hour_o); end
        tests_run++; if (minute_o !== 6'd0) begin tests_failed++; $display("FAIL %s_minute: got %0d expected 0", tag, minute_o); end
        tests_run++; if (second_o !== 6'd0) begin tests_failed++; $display("FAIL %s_second: got %0d expected 0", tag, second_o); end
        tests_run++; if (mode_o !== 2'b00) begin tests_failed++; $display("FAIL %s_mode: got %0d expected 0", tag, mode_o); end
        tests_run++; if (field_sel_o !== 3'b000) begin tests_failed++; $display("FAIL %s_field_sel: got %b expected 000", tag, field_sel_o); end
        tests_run++; if (blank_o !== 1'b0) begin tests_failed++; $display("FAIL %s_blank: got %b expected 0", tag, blank_o); end
        tests_run++; if (tick_1hz_o !== 1'b0) begin tests_failed++; $display("FAIL %s_tick: got %b expected 0", tag, tick_1hz_o); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
    endtask

    task automatic test_run_count();
        int last = 0, ticks = 0, ms = 0, mm = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (tick_1hz_o === 1'b1) begin
                ticks++;
                tests_run++; if (c - last != 10) begin tests_failed++; $display("FAIL tick_spacing: got %0d expected 10", c - last); end
                last = c;
                ms++;
                if (ms == 60) begin ms = 0; mm++; end
                tests_run++; if (second_o !== 6'(ms)) begin tests_failed++; $display("FAIL run_second: got %0d expected %0d", second_o, ms); end
            end
        end
        tests_run++; if (ticks != 60) begin tests_failed++; $display("FAIL run_tick_count: got %0d expected 60", ticks); end
        tests_run++; if (minute_o !== 6'(mm) || mm != 1) begin tests_failed++; $display("FAIL run_minute: got %0d expected 1", minute_o); end
        tests_run++; if (second_o !== 6'd0) begin tests_failed++; $display("FAIL run_second_end: got %0d expected 0", second_o); end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_mode [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [2:0] exp_sel  [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
        for (int i = 0; i < 4; i++) begin
            press_btn(1'b1, (i == 0) ? 20 : 10);
            tests_run++; if (mode_o !== exp_mode[i]) begin tests_failed++; $display("FAIL mode_cycle%0d: got %0d expected %0d", i, mode_o, exp_mode[i]); end
            tests_run++; if (field_sel_o !== exp_sel[i]) begin tests_failed++; $display("FAIL field_sel%0d: got %b expected %b", i, field_sel_o, exp_sel[i]); end
        end
    endtask

    // Reset, then press mode immediately so SET_H is reached before any tick.
    task automatic test_blink();
        int k = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        btn_mode = 1'b1;
        while (mode_o !== 2'b01 && k < 20) begin
            @(negedge clk);
            k++;
        end
        btn_mode = 1'b0;
        tests_run++; if (k < 7 || k > 9) begin tests_failed++; $display("FAIL press_latency: got %0d expected 8", k); end
        for (int j = 0; j < 40; j++) begin
            if (j > 0) @(negedge clk);
            tests_run++; if (blank_o !== 1'((j / 8) % 2)) begin tests_failed++; $display("FAIL blink_%0d: got %b expected %0d", j, blank_o, (j / 8) % 2); end
            tests_run++; if (tick_1hz_o !== 1'b0) begin tests_failed++; $display("FAIL set_tick_%0d: got %b expected 0", j, tick_1hz_o); end
            tests_run++; if (second_o !== 6'd0) begin tests_failed++; $display("FAIL set_frozen_%0d: got %0d expected 0", j, second_o); end
        end
    endtask

    task automatic test_glitch();
        for (int w = 1; w <= 3; w++) begin
            btn_inc = 1'b1;
            repeat (w) @(negedge clk);
            btn_inc = 1'b0;
            repeat (12) @(negedge clk);
            tests_run++; if (hour_o !== 6'd0) begin tests_failed++; $display("FAIL glitch_inc_%0d: got %0d expected 0", w, hour_o); end
        end
        for (int w = 1; w <= 3; w++) begin
            btn_mode = 1'b1;
            repeat (w) @(negedge clk);
            btn_mode = 1'b0;
            repeat (12) @(negedge clk);
            tests_run++; if (mode_o !== 2'b01) begin tests_failed++; $display("FAIL glitch_mode_%0d: got %0d expected 1", w, mode_o); end
        end
    endtask

    task automatic test_set_fields();
        repeat (23) press_btn(1'b0, 10);
        tests_run++; if (hour_o !== 6'd23) begin tests_failed++; $display("FAIL set_hour: got %0d expected 23", hour_o); end
        press_btn(1'b1, 10);
        tests_run++; if (mode_o !== 2'b10) begin tests_failed++; $display("FAIL enter_set_m: got %0d expected 2", mode_o); end
        repeat (59) press_btn(1'b0, 10);
        tests_run++; if (minute_o !== 6'd59) begin tests_failed++; $display("FAIL set_minute: got %0d expected 59", minute_o); end
        press_btn(1'b0, 10);
        tests_run++; if (minute_o !== 6'd0) begin tests_failed++; $display("FAIL minute_wrap: got %0d expected 0", minute_o); end
        tests_run++; if (hour_o !== 6'd23) begin tests_failed++; $display("FAIL minute_no_carry: got %0d expected 23", hour_o); end
        press_btn(1'b0, 100);
        tests_run++; if (minute_o !== 6'd1) begin tests_failed++; $display("FAIL hold_inc: got %0d expected 1", minute_o); end
        repeat (58) press_btn(1'b0, 10);
        press_btn(1'b1, 10);
        tests_run++; if (mode_o !== 2'b11) begin tests_failed++; $display("FAIL enter_set_s: got %0d expected 3", mode_o); end
        repeat (59) press_btn(1'b0, 10);
        tests_run++; if (second_o !== 6'd59) begin tests_failed++; $display("FAIL set_second: got %0d expected 59", second_o); end
        tests_run++; if (minute_o !== 6'd59) begin tests_failed++; $display("FAIL preload_minute: got %0d expected 59", minute_o); end
    endtask

    task automatic test_rollover();
        int k = 0, ticks = 0, tick_at = -1;
        btn_mode = 1'b1;
        while (mode_o !== 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        btn_mode = 1'b0;
        tests_run++; if (mode_o !== 2'b00) begin tests_failed++; $display("FAIL back_to_run: got %0d expected 0", mode_o); end
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            if (tick_1hz_o === 1'b1) begin ticks++; tick_at = j; end
            tests_run++; if (hour_o > 6'd23) begin tests_failed++; $display("FAIL hour_range_%0d: got %0d expected <=23", j, hour_o); end
            if (j == 9) begin
                tests_run++; if (second_o !== 6'd59) begin tests_failed++; $display("FAIL pre_tick_second: got %0d expected 59", second_o); end
            end
        end
        tests_run++; if (ticks != 1) begin tests_failed++; $display("FAIL rollover_ticks: got %0d expected 1", ticks); end
        tests_run++; if (tick_at != 10) begin tests_failed++; $display("FAIL first_tick_delay: got %0d expected 10", tick_at); end
        tests_run++; if (hour_o !== 6'd0 || minute_o !== 6'd0 || second_o !== 6'd0) begin
            tests_failed++; $display("FAIL rollover_time: got %0d:%0d:%0d expected 0:0:0", hour_o, minute_o, second_o);
        end
    endtask

    task automatic test_reset_mid_set();
        repeat (3) press_btn(1'b1, 10);
        tests_run++; if (mode_o !== 2'b11) begin tests_failed++; $display("FAIL reach_set_s: got %0d expected 3", mode_o); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (mode_o !== 2'b00) begin tests_failed++; $display("FAIL post_reset_mode: got %0d expected 0", mode_o); end
        tests_run++; if (second_o !== 6'd0) begin tests_failed++; $display("FAIL post_reset_second: got %0d expected 0", second_o); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run_count();
        test_mode_cycle();
        test_blink();
        test_glitch();
        test_set_fields();
        test_rollover();
        test_reset_mid_set();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Time-keeping and setting controller that drives the 6-bit `hour`/`minute`/`second` inputs of the 7-segment display driver. It counts real time from a 1 Hz prescaler and runs a run/set state machine controlled by two debounced push buttons (`btn_mode`, `btn_inc`). It also produces a blink control so the field being set can be flashed. It sits between the board buttons and the display scanner, in the same `clk` domain.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per 1 s tick.
- `DB_CYCLES`, 2_000_000: consecutive stable synchronized samples required to accept a button level (20 ms at 100 MHz).
- `BLINK_DIV`, 50_000_000: clk cycles per blink phase toggle.

- `clk`  in  1  system clock.
- `rst`  in  1  reset rst, asynchronous, active-low.
- `btn_mode`  in  1  raw, asynchronous, active-high mode button.
- `btn_inc`  in  1  raw, asynchronous, active-high increment button.
- `hour`  out  6  0..23, to display.
- `minute`  out  6  0..59, to display.
- `second`  out  6  0..59, to display.
- `mode`  out  2  00 RUN, 01 SET_H, 10 SET_M, 11 SET_S.
- `field_sel`  out  3  one-hot field being set: {hour, minute, second}. 000 in RUN.
- `blank`  out  1  1 = display should blank `field_sel` this phase.
- `tick_1hz`  out  1  one-cycle pulse on each counted second.

## Operation
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter, reloaded on any change of the synchronized sample. The debounced level takes the new value once the sample has been stable for DB_CYCLES cycles.
  - A rising edge of the debounced level makes a one-cycle `press` pulse.
  - Holding a button makes exactly one press. Releasing it makes none.
- FSM states: RUN → SET_H → SET_M → SET_S → RUN.
  - Each state advances on a `mode_press`. No other transitions.
  - Reset state is RUN.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - At TICK_DIV-1: the prescaler wraps to 0, `tick_1hz`=1 for one cycle, and `second` increments.
  - `second` 59→0 carries into `minute`. `minute` 59→0 carries into `hour`. `hour` 23→0.
  - 23:59:59 → 00:00:00 in one tick.
  - `inc_press` is ignored.
- SET states:
  - The prescaler is held at 0, `tick_1hz`=0 and no counting takes place.
  - `inc_press` increments only the selected field, with wrap (hour 23→0, minute/second 59→0) and no carry.
- Leaving SET_S for RUN: the prescaler is already 0, so the first tick comes TICK_DIV cycles after the transition.
- Same cycle as a tick in RUN:
  - `mode_press`: the tick (including carries) is applied and the FSM moves to SET_H.
  - `mode_press` and `inc_press` together in a SET state: the increment is applied to the current field, then the state advances.
- Blink:
  - The phase counter runs only in SET states and the phase toggles every BLINK_DIV cycles. `blank` equals the phase.
  - On every state change, the phase counter and phase are cleared to 0, so the field is shown first.
  - In RUN, `blank`=0 and the counter is held at 0.
- Field values are always in range; no out-of-range value can occur.

## Timing
- Reset (async assert, sync-safe release): `hour`=`minute`=`second`=0, `mode`=00, `field_sel`=000, `blank`=0, `tick_1hz`=0.
- Reset also clears the prescaler, debounce counters, synchronizers and debounced levels, and the blink counter.
- Reset mid-set returns to RUN at 00:00:00.
- All outputs are registered.
- Press latency:
  - A raw edge is reflected in `mode`/field outputs 2 (sync) + DB_CYCLES + 1 (edge detect) + 1 (update) cycles later, ±1 for sampling alignment.
- Tick spacing:
  - Exactly TICK_DIV cycles in uninterrupted RUN.
  - `second` changes on the same clock edge that raises `tick_1hz`.
- Glitches shorter than DB_CYCLES cycles produce no press.

## Test plan
Benches use TICK_DIV=10, DB_CYCLES=4, BLINK_DIV=8.
- Reset, then RUN for 600 cycles → `second` 0→59→0 and `minute`=1, with `tick_1hz` pulses exactly 10 cycles apart.
- Preload to 23:59:59 via set mode (23 hour presses, 59 minute presses, 59 second presses, back to RUN), then wait 10 cycles → 00:00:00 with one tick, and `hour` never shows 24.
- `btn_mode` high for 20 cycles → `mode`=01 and `field_sel`=100. A second press → 10. A third → 11. A fourth → 00.
- SET_M with `minute`=59, one `btn_inc` press → `minute`=0 and `hour` unchanged. Hold `btn_inc` for 100 cycles → exactly one increment.
- `btn_inc` glitch pulses of 1–3 cycles → no change. Same for `btn_mode`.
- SET_H, 40 cycles idle → `blank` toggles every 8 cycles starting at 0. `tick_1hz` stays 0 and `second` is frozen.
- Assert `rst` low mid-SET_S → all outputs are at reset values immediately. After release, `mode`=00.
